// File: rtl/simon_pkg.sv
// Shared Simon definitions: pad FSM encodings, debounce default and colour mapping.
// Also used by the game engine and display blocks.
package simon_pkg;

  localparam int DEBOUNCE_TICKS_DEF = 3;
  localparam int NUM_BTN            = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HELD    = 2'd1,
    ST_LOCKOUT = 2'd2
  } pad_state_e;

  typedef enum logic [1:0] {
    COL_GREEN  = 2'd0,
    COL_RED    = 2'd1,
    COL_YELLOW = 2'd2,
    COL_BLUE   = 2'd3
  } colour_e;

  function automatic colour_e btn_colour(input logic [1:0] idx);
    return colour_e'(idx);
  endfunction

  function automatic logic [3:0] idx_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Lowest set bit wins; callers only use it on one-hot vectors.
  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/simon_pad_debouncer.sv
// One-bit button conditioner: two-flop synchronizer followed by a hold-time debouncer.
module simon_pad_debouncer
  import simon_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);

  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The level flips on the cycle after the counter register shows DEBOUNCE_TICKS.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_TICKS)) level_d = ~level_q;
      else                                 cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b00;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/simon_pad.sv
// Player button pad: conditions four raw buttons and emits one pulse per clean single press.
//   state   | meaning
//   IDLE    | no debounced button high; waiting for a press
//   HELD    | accepted press held; padLed echoes playerNum
//   LOCKOUT | rejected press (multi-press or engine busy); wait for full release
module simon_pad
  import simon_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic       simonTurn,
  input  logic       gameOver,
  output logic [1:0] playerNum,
  output logic       playerPressed,
  output logic [3:0] padLed
);

  logic [3:0] deb;
  pad_state_e state_q, state_d;
  logic [1:0] num_q, num_d;
  logic       pressed_q, pressed_d;
  logic       any_high, single_high;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_deb
    simon_pad_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb (
      .clk     (clk),
      .reset   (reset),
      .btn_i   (btn[g]),
      .level_o (deb[g])
    );
  end

  assign any_high    = |deb;
  assign single_high = any_high && ((deb & (deb - 4'd1)) == 4'd0);

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    pressed_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_high) begin
          if (single_high && !simonTurn && !gameOver) begin
            state_d   = ST_HELD;
            num_d     = onehot_idx(deb);
            pressed_d = 1'b1;
          end else begin
            state_d = ST_LOCKOUT;
          end
        end
      end
      ST_HELD, ST_LOCKOUT: begin
        if (!any_high) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      num_q     <= 2'd0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      pressed_q <= pressed_d;
    end
  end

  assign playerNum     = num_q;
  assign playerPressed = pressed_q;
  assign padLed        = (state_q == ST_HELD) ? idx_onehot(num_q) : 4'b0000;

endmodule

// File: tb/tb_simon_pad.sv
// Directed self-checking bench for simon_pad with DEBOUNCE_TICKS = 3.
module tb_simon_pad;

  logic       clk;
  logic       reset;
  logic [3:0] btn;
  logic       simonTurn;
  logic       gameOver;
  logic [1:0] playerNum;
  logic       playerPressed;
  logic [3:0] padLed;

  int checks   = 0;
  int failures = 0;

  // Per-cycle observations gathered by run_cycles
  int         pulses;
  int         first_at;
  logic [3:0] led_or;
  logic [3:0] led_log [0:31];

  simon_pad #(.DEBOUNCE_TICKS(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .btn           (btn),
    .simonTurn     (simonTurn),
    .gameOver      (gameOver),
    .playerNum     (playerNum),
    .playerPressed (playerPressed),
    .padLed        (padLed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Index i holds the outputs sampled 1 time unit after edge k+i.
  task automatic run_cycles(input int n);
    pulses   = 0;
    first_at = -1;
    led_or   = 4'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (playerPressed === 1'b1) begin
        pulses++;
        if (first_at < 0) first_at = i;
      end else if (playerPressed !== 1'b0) begin
        pulses += 100;
      end
      led_or     = led_or | padLed;
      led_log[i] = padLed;
    end
  endtask

  task automatic release_all();
    btn = 4'b0000;
    run_cycles(10);
  endtask

  task automatic test_reset();
    btn = 4'b0000; simonTurn = 1'b0; gameOver = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (playerPressed !== 1'b0) begin failures++; $display("FAIL reset_pressed got=%b exp=0", playerPressed); end
    checks++; if (playerNum !== 2'd0) begin failures++; $display("FAIL reset_num got=%0d exp=0", playerNum); end
    checks++; if (padLed !== 4'b0000) begin failures++; $display("FAIL reset_led got=%b exp=0000", padLed); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_press();
    btn = 4'b0010;
    run_cycles(10);
    checks++; if (pulses != 1) begin failures++; $display("FAIL press_pulses got=%0d exp=1", pulses); end
    checks++; if (first_at != 6) begin failures++; $display("FAIL press_latency got=%0d exp=6", first_at); end
    checks++; if (playerNum !== 2'd1) begin failures++; $display("FAIL press_num got=%0d exp=1", playerNum); end
    checks++; if (led_log[9] !== 4'b0010) begin failures++; $display("FAIL press_led got=%b exp=0010", led_log[9]); end
    btn = 4'b0000;
    run_cycles(10);
    checks++; if (led_log[5] !== 4'b0010) begin failures++; $display("FAIL release_led_hold got=%b exp=0010", led_log[5]); end
    checks++; if (led_log[6] !== 4'b0000) begin failures++; $display("FAIL release_led_off got=%b exp=0000", led_log[6]); end
    checks++; if (pulses != 0) begin failures++; $display("FAIL release_pulses got=%0d exp=0", pulses); end
  endtask

  task automatic test_glitch();
    btn = 4'b0100;
    run_cycles(2);
    btn = 4'b0000;
    run_cycles(10);
    checks++; if (pulses != 0) begin failures++; $display("FAIL glitch_pulses got=%0d exp=0", pulses); end
    checks++; if (playerNum !== 2'd1) begin failures++; $display("FAIL glitch_num got=%0d exp=1", playerNum); end
    checks++; if (led_or !== 4'b0000) begin failures++; $display("FAIL glitch_led got=%b exp=0000", led_or); end
  endtask

  task automatic test_multi_press();
    btn = 4'b1001;
    run_cycles(8);
    checks++; if (pulses != 0) begin failures++; $display("FAIL multi_pulses got=%0d exp=0", pulses); end
    checks++; if (playerNum !== 2'd1) begin failures++; $display("FAIL multi_num got=%0d exp=1", playerNum); end
    checks++; if (led_or !== 4'b0000) begin failures++; $display("FAIL multi_led got=%b exp=0000", led_or); end
    release_all();
    btn = 4'b1000;
    run_cycles(10);
    checks++; if (pulses != 1 || first_at != 6) begin failures++; $display("FAIL after_multi_pulse got=%0d@%0d exp=1@6", pulses, first_at); end
    checks++; if (playerNum !== 2'd3) begin failures++; $display("FAIL after_multi_num got=%0d exp=3", playerNum); end
    release_all();
  endtask

  task automatic test_simon_turn();
    simonTurn = 1'b1;
    btn = 4'b0001;
    run_cycles(8);
    checks++; if (pulses != 0) begin failures++; $display("FAIL simon_busy_pulses got=%0d exp=0", pulses); end
    simonTurn = 1'b0;
    run_cycles(8);
    checks++; if (pulses != 0) begin failures++; $display("FAIL simon_drop_pulses got=%0d exp=0", pulses); end
    checks++; if (playerNum !== 2'd3) begin failures++; $display("FAIL simon_num_kept got=%0d exp=3", playerNum); end
    release_all();
    btn = 4'b0001;
    run_cycles(10);
    checks++; if (pulses != 1 || first_at != 6) begin failures++; $display("FAIL simon_repress got=%0d@%0d exp=1@6", pulses, first_at); end
    checks++; if (playerNum !== 2'd0) begin failures++; $display("FAIL simon_repress_num got=%0d exp=0", playerNum); end
    release_all();
  endtask

  task automatic test_game_over();
    gameOver = 1'b1;
    btn = 4'b0100;
    run_cycles(10);
    checks++; if (pulses != 0) begin failures++; $display("FAIL gameover_pulses got=%0d exp=0", pulses); end
    gameOver = 1'b0;
    release_all();
  endtask

  task automatic test_reset_mid_held();
    btn = 4'b0100;
    run_cycles(8);
    checks++; if (pulses != 1 || first_at != 6) begin failures++; $display("FAIL pre_reset_pulse got=%0d@%0d exp=1@6", pulses, first_at); end
    #2 reset = 1'b1;
    #1;
    checks++; if (playerNum !== 2'd0 || padLed !== 4'b0000 || playerPressed !== 1'b0) begin
      failures++; $display("FAIL mid_reset_outputs got=%0d/%b/%b exp=0/0000/0", playerNum, padLed, playerPressed);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    run_cycles(10);
    checks++; if (pulses != 1 || first_at != 6) begin failures++; $display("FAIL post_reset_pulse got=%0d@%0d exp=1@6", pulses, first_at); end
    checks++; if (playerNum !== 2'd2) begin failures++; $display("FAIL post_reset_num got=%0d exp=2", playerNum); end
    release_all();
  endtask

  task automatic test_back_to_back();
    btn = 4'b0001;
    run_cycles(10);
    checks++; if (pulses != 1) begin failures++; $display("FAIL held_first_pulse got=%0d exp=1", pulses); end
    btn = 4'b0011;
    run_cycles(10);
    checks++; if (pulses != 0) begin failures++; $display("FAIL held_extra_pulses got=%0d exp=0", pulses); end
    checks++; if (led_log[9] !== 4'b0001) begin failures++; $display("FAIL held_extra_led got=%b exp=0001", led_log[9]); end
    btn = 4'b0000;
    run_cycles(10);
    checks++; if (pulses != 0 || padLed !== 4'b0000) begin failures++; $display("FAIL held_release got=%0d/%b exp=0/0000", pulses, padLed); end
    btn = 4'b0010;
    run_cycles(10);
    checks++; if (pulses != 1 || playerNum !== 2'd1) begin failures++; $display("FAIL idle_after_release got=%0d/%0d exp=1/1", pulses, playerNum); end
    release_all();
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_multi_press();
    test_simon_turn();
    test_game_over();
    test_reset_mid_held();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
